serial_byte_deserializer: RTL and testbench
===========================================

// Module: serial_byte_deserializer
// PURPOSE
//   Receive end of the team's bidirectional shift-register serial link.
//   Collects WIDTH bits from a serial line in either shift direction.
//   Presents each completed word on a parallel output with a valid/ready handshake.
//   Sits downstream of the parallel-load left/right shift transmitter and restores its loaded word.
// PARAMETERS
//   WIDTH  8  bits per word; legal range >= 2
// PORTS
//   clk               in   1      rising-edge clock, the only clock
//   reset             in   1      asynchronous, active-low; clears all state
//   clear             in   1      sync; aborts partial word, clears overrun
//   left_right_shift  in   1      0 = MSB-first (tx shifts left); 1 = LSB-first (tx shifts right)
//   bit_valid         in   1      serial_in holds a valid bit this cycle
//   serial_in         in   1      serial data bit
//   data_out          out  WIDTH  completed word
//   data_valid        out  1      data_out holds an unconsumed word
//   data_ready        in   1      consumer accepts data_out when data_valid=1
//   overrun           out  1      sticky; a completed word was dropped
//   bit_count         out  clog2(WIDTH)  bits received in the current word
// BEHAVIOUR
//   Reset (reset=0, async): shreg=0, bit_count=0, dir_lat=0, state=IDLE.
//     Also data_out=0, data_valid=0, overrun=0.
//   States: IDLE (bit_count==0), RECV (0<bit_count<WIDTH).
//   IDLE + bit_valid: latch dir_lat<=left_right_shift, shift bit in, bit_count<=1, go RECV.
//   Direction is taken only at the first bit of a word.
//     Changes to left_right_shift mid-word are ignored.
//   Shift on each accepted bit, using dir_lat (or the live input on the first bit):
//     dir 0: shreg <= {shreg[WIDTH-2:0], serial_in}  (first bit ends in MSB)
//     dir 1: shreg <= {serial_in, shreg[WIDTH-1:1]}  (first bit ends in LSB)
//   bit_valid=0: no shift, no count change.
//     Gaps between bits of any length are allowed.
//   Completion: bit_valid=1 with bit_count==WIDTH-1.
//     The shifted word (including this bit) is complete on that edge.
//     bit_count wraps to 0 and state goes to IDLE.
//   Output: on completion, if the slot is free, data_out<=word and data_valid<=1 on that same edge.
//     Latency is 0 cycles after the last bit edge.
//   Slot free = (data_valid==0) or (data_ready==1) in the completion cycle.
//   Handshake: transfer occurs when data_valid & data_ready at a rising edge.
//     Transfer with no completion: data_valid<=0 and data_out holds its value.
//   data_valid and data_out must stay stable while data_valid=1 and data_ready=0.
//   Simultaneous completion + data_ready: the new word is loaded, data_valid stays 1, no overrun.
//   Completion while data_valid=1 & data_ready=0: the new word is dropped and overrun<=1.
//     data_out keeps the old word. overrun stays set until clear or reset.
//   clear=1: shreg<=0, bit_count<=0, state<=IDLE, overrun<=0.
//     data_out and data_valid are unaffected. clear has priority over bit_valid that cycle.
//   Reset mid-word: the partial word is lost and the held output word is discarded.
// TESTING
//   1. left_right_shift=0; bits 1,0,1,1,0,0,1,0 on consecutive cycles.
//      -> data_valid=1 on the 8th edge, data_out=8'hB2.
//   2. left_right_shift=1; same bits.
//      -> data_out=8'h4D. Toggle left_right_shift after bit 3 -> still 8'h4D.
//   3. data_ready=0; send 8'hB2 then 8'hFF MSB-first.
//      -> data_out stays 8'hB2, overrun=1 after the 16th bit; clear -> overrun=0.
//   4. data_ready=1 continuously; back-to-back words 8'h01, 8'h80.
//      -> data_valid high through the completion edges, data_out 8'h01 then 8'h80, overrun=0.
//   5. Send 4 bits, then clear, then 8 bits of 8'hA5 MSB-first.
//      -> data_out=8'hA5; bit_count returns 0.
//   6. Assert reset low mid-word and mid-hold (data_valid=1).
//      -> all outputs 0 immediately, without waiting for a clock edge.
//      Random gaps in bit_valid must not change the results of tests 1-2.

Source files
------------

// File: rtl/serial_byte_deserializer.sv
// Receive side of the bidirectional shift-register serial link: gathers WIDTH
// serial bits in either shift order and hands each word out over valid/ready.
module serial_byte_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     left_right_shift,
  input  logic                     bit_valid,
  input  logic                     serial_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;

  logic             dir_eff;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             slot_free;

  // The shift order is latched on the first bit of a word; later changes are ignored.
  always_comb begin
    dir_eff   = (state_q == IDLE) ? left_right_shift : dir_q;
    shifted   = dir_eff ? {serial_in, shreg_q[WIDTH-1:1]}
                        : {shreg_q[WIDTH-2:0], serial_in};
    complete  = bit_valid && (count_q == LAST);
    slot_free = !data_valid_q || data_ready;
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    dir_d        = dir_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    if (clear) begin
      state_d   = IDLE;
      shreg_d   = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else if (bit_valid) begin
      dir_d = dir_eff;
      if (complete) begin
        state_d = IDLE;
        shreg_d = '0;
        count_d = '0;
        // A finished word that finds the slot occupied is dropped, keeping the older word.
        if (slot_free) begin
          data_out_d   = shifted;
          data_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        state_d = RECV;
        shreg_d = shifted;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      count_q      <= '0;
      dir_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      dir_q        <= dir_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign bit_count  = count_q;

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Bench for serial_byte_deserializer: a table of known words, hand-built
// handshake/clear/reset sequences, then random traffic against a word-level model.
module tb_serial_byte_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         left_right_shift;
  logic         bit_valid;
  logic         serial_in;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         overrun;
  logic [2:0]   bit_count;

  int checksRun    = 0;
  int checksPassed = 0;

  typedef struct {
    logic         dir;
    logic [W-1:0] bits;
    logic         toggle;
    logic [W-1:0] expOut;
  } vec_t;

  vec_t vecs[6];

  logic         mq[$];
  logic         mDir;
  logic [W-1:0] mOut;
  logic         mValid;
  logic         mOverrun;
  logic [W-1:0] word;
  logic         mXfer;

  serial_byte_deserializer #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .clear            (clear),
    .left_right_shift (left_right_shift),
    .bit_valid        (bit_valid),
    .serial_in        (serial_in),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .overrun          (overrun),
    .bit_count        (bit_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksRun++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
  endtask

  task automatic sendBit(input logic dir, input logic b);
    left_right_shift = dir;
    serial_in        = b;
    bit_valid        = 1'b1;
    tick();
    bit_valid        = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    bit_valid = 1'b0;
    repeat (n) begin
      serial_in        = 1'($urandom);
      left_right_shift = 1'($urandom);
      tick();
    end
  endtask

  // Sends bits[W-1] first; toggle flips the direction input from the 4th bit on.
  task automatic applyStimulus(input logic dir, input logic [W-1:0] bits, input logic toggle,
                               input logic gaps, input logic checkEarly, input string name);
    for (int i = 0; i < W; i++) begin
      if (gaps) idleCycles($urandom_range(0, 3));
      sendBit((toggle && i >= 3) ? ~dir : dir, bits[W-1-i]);
      if (i == 3) checkOutput({name, " count4"}, 32'(bit_count), 32'd4);
      if (checkEarly && i == W-2) checkOutput({name, " early valid"}, 32'(data_valid), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hB2, 1'b0, 8'hB2};
    vecs[1] = '{1'b1, 8'hB2, 1'b0, 8'h4D};
    vecs[2] = '{1'b1, 8'hB2, 1'b1, 8'h4D};
    vecs[3] = '{1'b0, 8'h01, 1'b1, 8'h01};
    vecs[4] = '{1'b1, 8'h01, 1'b0, 8'h80};
    vecs[5] = '{1'b1, 8'hF0, 1'b0, 8'h0F};

    reset = 1'b0; clear = 1'b0; left_right_shift = 1'b0;
    bit_valid = 1'b0; serial_in = 1'b0; data_ready = 1'b0;
    #12;
    checkOutput("reset data_out", 32'(data_out), 32'd0);
    checkOutput("reset data_valid", 32'(data_valid), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    checkOutput("reset bit_count", 32'(bit_count), 32'd0);
    reset = 1'b1;
    tick();

    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v < 6; v++) begin
        string nm;
        nm = $sformatf("vec%0d/gaps%0d", v, pass);
        data_ready = 1'b0;
        applyStimulus(vecs[v].dir, vecs[v].bits, vecs[v].toggle, pass[0], 1'b1, nm);
        checkOutput({nm, " valid"}, 32'(data_valid), 32'd1);
        checkOutput({nm, " data"}, 32'(data_out), 32'(vecs[v].expOut));
        checkOutput({nm, " count"}, 32'(bit_count), 32'd0);
        data_ready = 1'b1;
        tick();
        checkOutput({nm, " consumed"}, 32'(data_valid), 32'd0);
        checkOutput({nm, " data hold"}, 32'(data_out), 32'(vecs[v].expOut));
        data_ready = 1'b0;
      end
    end

    // Overrun: second word arrives while the first is still unconsumed.
    applyStimulus(1'b0, 8'hB2, 1'b0, 1'b0, 1'b0, "ovr first");
    checkOutput("ovr first data", 32'(data_out), 32'hB2);
    checkOutput("ovr first overrun", 32'(overrun), 32'd0);
    applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, "ovr second");
    checkOutput("ovr held data", 32'(data_out), 32'hB2);
    checkOutput("ovr held valid", 32'(data_valid), 32'd1);
    checkOutput("ovr sticky", 32'(overrun), 32'd1);
    idleCycles(3);
    checkOutput("ovr still sticky", 32'(overrun), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("ovr cleared", 32'(overrun), 32'd0);
    checkOutput("clear keeps valid", 32'(data_valid), 32'd1);
    checkOutput("clear keeps data", 32'(data_out), 32'hB2);
    data_ready = 1'b1;
    tick();

    // Back-to-back words with the consumer always ready.
    applyStimulus(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, "b2b first");
    checkOutput("b2b first data", 32'(data_out), 32'h01);
    checkOutput("b2b first valid", 32'(data_valid), 32'd1);
    applyStimulus(1'b0, 8'h80, 1'b0, 1'b0, 1'b0, "b2b second");
    checkOutput("b2b second data", 32'(data_out), 32'h80);
    checkOutput("b2b second valid", 32'(data_valid), 32'd1);
    checkOutput("b2b overrun", 32'(overrun), 32'd0);
    tick();
    data_ready = 1'b0;

    // Completion on the same edge as the consumer draining a held word.
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, "swap first");
    checkOutput("swap first data", 32'(data_out), 32'h3C);
    for (int i = 0; i < W-1; i++) sendBit(1'b0, word_bit(8'hC3, i));
    checkOutput("swap hold data", 32'(data_out), 32'h3C);
    data_ready = 1'b1;
    sendBit(1'b0, word_bit(8'hC3, W-1));
    checkOutput("swap new data", 32'(data_out), 32'hC3);
    checkOutput("swap valid", 32'(data_valid), 32'd1);
    checkOutput("swap overrun", 32'(overrun), 32'd0);
    tick();
    data_ready = 1'b0;
    checkOutput("swap drained", 32'(data_valid), 32'd0);

    // Clear mid-word, including clear racing a valid bit.
    sendBit(1'b0, 1'b1); sendBit(1'b0, 1'b0); sendBit(1'b0, 1'b1); sendBit(1'b0, 1'b0);
    checkOutput("partial count", 32'(bit_count), 32'd4);
    clear = 1'b1;
    sendBit(1'b0, 1'b1);
    clear = 1'b0;
    checkOutput("clear count", 32'(bit_count), 32'd0);
    applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, "after clear");
    checkOutput("after clear data", 32'(data_out), 32'hA5);
    checkOutput("after clear count", 32'(bit_count), 32'd0);

    // Async reset while holding a word, with overrun set and a partial word in flight.
    applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, "pre reset");
    checkOutput("pre reset overrun", 32'(overrun), 32'd1);
    sendBit(1'b0, 1'b1); sendBit(1'b0, 1'b1); sendBit(1'b0, 1'b0);
    checkOutput("pre reset count", 32'(bit_count), 32'd3);
    #2 reset = 1'b0;
    #1;
    checkOutput("async data_out", 32'(data_out), 32'd0);
    checkOutput("async data_valid", 32'(data_valid), 32'd0);
    checkOutput("async overrun", 32'(overrun), 32'd0);
    checkOutput("async bit_count", 32'(bit_count), 32'd0);
    #1 reset = 1'b1;
    tick();

    // Random traffic against a word-level model of the link.
    mq.delete();
    mDir = 1'b0; mOut = '0; mValid = 1'b0; mOverrun = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit_valid        = ($urandom_range(0, 2) != 0);
      serial_in        = 1'($urandom);
      left_right_shift = 1'($urandom);
      data_ready       = ($urandom_range(0, 3) == 0);
      clear            = ($urandom_range(0, 40) == 0);

      mXfer = mValid && data_ready;
      if (clear) begin
        mq.delete();
        mOverrun = 1'b0;
        if (mXfer) mValid = 1'b0;
      end else begin
        if (bit_valid) begin
          if (mq.size() == 0) mDir = left_right_shift;
          mq.push_back(serial_in);
        end
        if (mq.size() == W) begin
          word = '0;
          for (int k = 0; k < W; k++) begin
            if (mDir) word[k] = mq[k];
            else      word[W-1-k] = mq[k];
          end
          mq.delete();
          if (!mValid || data_ready) begin
            mOut   = word;
            mValid = 1'b1;
          end else begin
            mOverrun = 1'b1;
          end
        end else if (mXfer) begin
          mValid = 1'b0;
        end
      end

      tick();
      checkOutput($sformatf("random cycle %0d", cyc),
                  32'({data_valid, data_out, overrun, bit_count}),
                  32'({mValid, mOut, mOverrun, 3'(mq.size())}));
    end

    clear = 1'b0; bit_valid = 1'b0; data_ready = 1'b0;
    tick();
    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

  function automatic logic word_bit(input logic [W-1:0] w, input int i);
    return w[W-1-i];
  endfunction

endmodule
